seed_out_collector: RTL and testbench

SEED_OUT_COLLECTOR -- requirements
Module: seed_out_collector

---
 rtl/seed_pkg.sv | 18 +
 rtl/seed_blk_fifo.sv | 68 ++++++
 rtl/seed_out_collector.sv | 98 +++++++++
 tb/tb_seed_out_collector.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// Shared constants and types for the SEED ciphertext output path.
package seed_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } collect_state_e;

  // LSB position of byte idx inside an MSB-first block.
  function automatic logic [6:0] byte_lsb(input logic [CNT_W-1:0] idx);
    return 7'(BLOCK_W - 8) - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/seed_blk_fifo.sv
// Two-entry block FIFO; slot0 is always the head and empty slots read as zero.
module seed_blk_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [seed_pkg::BLOCK_W-1:0] push_data,
  input  logic                         pop,
  output logic [seed_pkg::BLOCK_W-1:0] head,
  output logic                         empty,
  output logic                         full
);
  import seed_pkg::*;

  logic [BLOCK_W-1:0] slot0_q, slot1_q, slot0_d, slot1_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  // Pop frees a slot in the same cycle, so push-while-full is accepted alongside a pop.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'(DEPTH)) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data;
        else                 slot1_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        slot1_d = '0;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      empty   <= (count_d == 2'd0);
      full    <= (count_d == 2'(DEPTH));
    end
  end

  assign head = slot0_q;

endmodule

// File: rtl/seed_out_collector.sv
// Assembles serial SEED ciphertext bytes into 128-bit blocks and buffers them.
module seed_out_collector #(
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   in_byte,
  input  logic                         in_valid,
  output logic [seed_pkg::BLOCK_W-1:0] out_block,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         frame_err,
  output logic                         overrun,
  input  logic                         clr_err
);
  import seed_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BYTES - 1);

  collect_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BLOCK_W-1:0] asm_q, asm_d;
  logic               frame_err_d;
  logic               push_c, pop_c, ovr_c;
  logic               fifo_empty, fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      asm_q     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      frame_err <= frame_err_d;
      // A fresh drop wins over a coincident clear.
      if (ovr_c)        overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

  // Next-state, byte placement and completion push.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    frame_err_d = 1'b0;
    push_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          asm_d[byte_lsb('0) +: 8] = in_byte;
          cnt_d   = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          asm_d[byte_lsb(cnt_q) +: 8] = in_byte;
          if (cnt_q == LAST) begin
            push_c  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = ~fifo_empty;
  assign pop_c     = out_valid & out_ready;
  assign ovr_c     = push_c & fifo_full & ~pop_c;

  seed_blk_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (asm_d),
    .pop       (pop_c),
    .head      (out_block),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_seed_out_collector.sv
// Scoreboard bench for seed_out_collector.
module tb_seed_out_collector;

  logic         clk;
  logic         reset;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;
  logic         overrun;
  logic         clr_err;

  int errors = 0;
  int checks = 0;
  int fe_cnt = 0;
  int fe_base;
  logic [127:0] exp_q[$];

  seed_out_collector #(
    .BLOCK_BYTES (16),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .out_block (out_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every accepted block is compared against the scoreboard head.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_block", 128'(out_valid), 128'(0));
      else check("block", out_block, exp_q.pop_front());
    end
  end

  task automatic send_block(input logic [127:0] blk, input bit expect_out, input bit ready_on_last);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_byte  = blk[127-8*i -: 8];
      if (i == 15) begin
        if (ready_on_last) out_ready = 1'b1;
        if (expect_out) exp_q.push_back(blk);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    check("empty_after_drain", 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] blk;
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_block", out_block, 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
    check("rst_overrun", 128'(overrun), 128'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Single block with consumer ready.
    out_ready = 1'b1;
    fe_base = fe_cnt;
    send_block(128'h000102030405060708090A0B0C0D0E0F, 1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    check("t1_valid_rise", 128'(out_valid), 128'(1));
    @(negedge clk);
    check("t1_valid_one_cycle", 128'(out_valid), 128'(0));
    check("t1_no_frame_err", 128'(fe_cnt - fe_base), 128'(0));

    // Partial block followed by a one-cycle gap.
    fe_base = fe_cnt;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_byte  = 8'hA0 + 8'(i);
    end
    idle(1);
    send_block(128'h101112131415161718191A1B1C1D1E1F, 1'b1, 1'b0);
    idle(1);
    drain();
    check("t2_frame_err_once", 128'(fe_cnt - fe_base), 128'(1));

    // Backpressure: third block is dropped and flags overrun.
    out_ready = 1'b0;
    send_block({16{8'h11}}, 1'b1, 1'b0);
    send_block({16{8'h22}}, 1'b1, 1'b0);
    send_block({16{8'h33}}, 1'b0, 1'b0);
    idle(1);
    @(negedge clk);
    check("t3_overrun_set", 128'(overrun), 128'(1));
    check("t3_valid_held", 128'(out_valid), 128'(1));
    check("t3_head", out_block, {16{8'h11}});
    repeat (3) @(negedge clk);
    check("t3_head_stable", out_block, {16{8'h11}});
    check("t3_overrun_sticky", 128'(overrun), 128'(1));
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    @(negedge clk);
    check("t3_overrun_clr", 128'(overrun), 128'(0));
    out_ready = 1'b1;
    drain();

    // Full FIFO with a pop in the exact cycle the third block completes.
    out_ready = 1'b0;
    send_block({16{8'h41}}, 1'b1, 1'b0);
    send_block({16{8'h52}}, 1'b1, 1'b0);
    send_block({16{8'h63}}, 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    check("t4_no_overrun", 128'(overrun), 128'(0));
    drain();

    // Reset mid-block with a buffered block pending.
    out_ready = 1'b0;
    fe_base = fe_cnt;
    send_block({16{8'hCC}}, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_byte  = 8'h90 + 8'(i);
    end
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("t5_valid_in_reset", 128'(out_valid), 128'(0));
    check("t5_block_in_reset", out_block, 128'(0));
    @(posedge clk); #1 reset = 1'b0;
    out_ready = 1'b1;
    blk = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    send_block(blk, 1'b1, 1'b0);
    idle(1);
    drain();
    check("t5_no_frame_err", 128'(fe_cnt - fe_base), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
